// File: rtl/decode_stage.sv
// decode_stage: RV32I decode front-end with a DEPTH-entry buffer of decoded
// instructions. Each instruction is decoded as it is enqueued and held with
// its pc until the consumer takes it with a valid/ready handshake.
//
// Optional feature: define DECODE_ILLEGAL_CHECK_EN to flag words that are not
// one of the eleven recognised RV32I major opcodes. Without the macro,
// out_illegal is tied low and unknown opcodes decode as R-format.
module decode_stage #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  input  logic [31:0] in_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [6:0]  out_opcode,
  output logic [4:0]  out_rd,
  output logic [2:0]  out_funct3,
  output logic [4:0]  out_rs1,
  output logic [4:0]  out_rs2,
  output logic        out_funct7b5,
  output logic [31:0] out_imm,
  output logic        out_use_imm,
  output logic        out_illegal,
  output logic [31:0] out_pc
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  // RV32I major opcodes
  localparam logic [6:0] OP_LOAD     = 7'b0000011;
  localparam logic [6:0] OP_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_JALR     = 7'b1100111;
  localparam logic [6:0] OP_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM   = 7'b1110011;
  localparam logic [6:0] OP_STORE    = 7'b0100011;
  localparam logic [6:0] OP_BRANCH   = 7'b1100011;
  localparam logic [6:0] OP_LUI      = 7'b0110111;
  localparam logic [6:0] OP_AUIPC    = 7'b0010111;
  localparam logic [6:0] OP_JAL      = 7'b1101111;
  localparam logic [6:0] OP_OP       = 7'b0110011;

  typedef enum logic [2:0] {
    FMT_R,
    FMT_I,
    FMT_S,
    FMT_B,
    FMT_U,
    FMT_J
  } fmt_e;

  typedef struct packed {
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        funct7b5;
    logic [31:0] imm;
    logic        use_imm;
    logic        illegal;
    logic [31:0] pc;
  } entry_t;

  // Decode signals for the incoming word
  logic [6:0]  dec_opcode;
  fmt_e        dec_fmt;
  logic        dec_use_imm;
  logic [31:0] dec_imm;
  logic        dec_illegal;
  entry_t      wr_entry;

  // Buffer state
  entry_t             mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q,  count_d;
  logic               push_en;
  logic               pop_en;
  entry_t             head;

  assign dec_opcode = in_instr[6:0];

  // Classify the incoming opcode into an immediate format
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path through the case leaves it unassigned and infers a latch.
    dec_fmt     = FMT_R;
    dec_use_imm = 1'b0;
    unique case (dec_opcode)
      OP_LOAD, OP_OP_IMM, OP_JALR: begin
        dec_fmt     = FMT_I;
        dec_use_imm = 1'b1;
      end
      OP_MISC_MEM, OP_SYSTEM: begin
        dec_fmt     = FMT_I;
      end
      OP_STORE: begin
        dec_fmt     = FMT_S;
        dec_use_imm = 1'b1;
      end
      OP_BRANCH: begin
        dec_fmt     = FMT_B;
        dec_use_imm = 1'b1;
      end
      OP_LUI, OP_AUIPC: begin
        dec_fmt     = FMT_U;
        dec_use_imm = 1'b1;
      end
      OP_JAL: begin
        dec_fmt     = FMT_J;
        dec_use_imm = 1'b1;
      end
      default: begin
        // OP_OP and unrecognised words: register format, no immediate
        dec_fmt     = FMT_R;
        dec_use_imm = 1'b0;
      end
    endcase
  end

  // Assemble the sign-extended immediate for the selected format
  always_comb begin
    dec_imm = '0;
    unique case (dec_fmt)
      FMT_I: dec_imm = {{20{in_instr[31]}}, in_instr[31:20]};
      FMT_S: dec_imm = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
      FMT_B: dec_imm = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                        in_instr[30:25], in_instr[11:8], 1'b0};
      FMT_U: dec_imm = {in_instr[31:12], 12'b0};
      FMT_J: dec_imm = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                        in_instr[20], in_instr[30:21], 1'b0};
      default: dec_imm = '0;
    endcase
  end

`ifdef DECODE_ILLEGAL_CHECK_EN
  // Flag anything that is not a 32-bit encoding of a recognised major opcode
  always_comb begin
    dec_illegal = 1'b1;
    if (in_instr[1:0] == 2'b11) begin
      unique case (dec_opcode)
        OP_LOAD, OP_OP_IMM, OP_JALR, OP_MISC_MEM, OP_SYSTEM, OP_STORE,
        OP_BRANCH, OP_LUI, OP_AUIPC, OP_JAL, OP_OP: dec_illegal = 1'b0;
        default:                                    dec_illegal = 1'b1;
      endcase
    end
  end
`else
  // Illegal detection disabled: unknown words simply decode as R-format
  always_comb begin
    dec_illegal = 1'b0;
  end
`endif

  // Pack the decoded fields; register/funct fields are taken verbatim
  always_comb begin
    wr_entry.opcode   = dec_opcode;
    wr_entry.rd       = in_instr[11:7];
    wr_entry.funct3   = in_instr[14:12];
    wr_entry.rs1      = in_instr[19:15];
    wr_entry.rs2      = in_instr[24:20];
    wr_entry.funct7b5 = in_instr[30];
    wr_entry.imm      = dec_imm;
    wr_entry.use_imm  = dec_use_imm;
    wr_entry.illegal  = dec_illegal;
    wr_entry.pc       = in_pc;
  end

  // Handshake flags come from registered occupancy only
  assign in_ready  = (count_q < CNT_W'(DEPTH));
  assign out_valid = (count_q != '0);
  assign push_en   = in_valid & in_ready & ~flush;
  assign pop_en    = out_valid & out_ready & ~flush;

  // Next pointer/occupancy; flush wins over push and pop
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_en) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_en)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      unique case ({push_en, pop_en})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control state register with asynchronous clear
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage write port
  always_ff @(posedge clk) begin
    // NOTE: storage is deliberately not reset; occupancy gates every read,
    // so stale contents are never visible and the array maps to plain RAM.
    if (push_en) mem_q[wr_ptr_q] <= wr_entry;
  end

  // Head entry, forced to zero when nothing is buffered
  always_comb begin
    head = '0;
    if (out_valid) head = mem_q[rd_ptr_q];
  end

  assign out_opcode   = head.opcode;
  assign out_rd       = head.rd;
  assign out_funct3   = head.funct3;
  assign out_rs1      = head.rs1;
  assign out_rs2      = head.rs2;
  assign out_funct7b5 = head.funct7b5;
  assign out_imm      = head.imm;
  assign out_use_imm  = head.use_imm;
  assign out_illegal  = head.illegal;
  assign out_pc       = head.pc;

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed scenarios followed by randomized traffic, with
// outputs compared each cycle against a queue-based reference model.
module tb_decode_stage;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        out_valid;
  logic        out_ready;
  logic [6:0]  out_opcode;
  logic [4:0]  out_rd;
  logic [2:0]  out_funct3;
  logic [4:0]  out_rs1;
  logic [4:0]  out_rs2;
  logic        out_funct7b5;
  logic [31:0] out_imm;
  logic        out_use_imm;
  logic        out_illegal;
  logic [31:0] out_pc;

  int checks = 0;
  int passes = 0;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } ent_t;
  ent_t model_q[$];

  decode_stage #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_opcode(out_opcode), .out_rd(out_rd), .out_funct3(out_funct3),
    .out_rs1(out_rs1), .out_rs2(out_rs2), .out_funct7b5(out_funct7b5),
    .out_imm(out_imm), .out_use_imm(out_use_imm), .out_illegal(out_illegal),
    .out_pc(out_pc)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: observed no finish, expected finish before 1ms");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Reference decode from the RV32I encoding rules, using integer arithmetic
  function automatic logic [91:0] ref_out(input logic [31:0] w, input logic [31:0] pc);
    logic [6:0]         op;
    logic signed [31:0] sra20;
    logic [31:0]        imm;
    logic               use_imm;
    logic               ill;
    int                 v;
    op      = w[6:0];
    sra20   = $signed(w) >>> 20;
    imm     = 32'h0;
    use_imm = op inside {7'b0000011, 7'b0010011, 7'b1100111, 7'b0100011,
                         7'b1100011, 7'b0110111, 7'b0010111, 7'b1101111};
    if (op inside {7'b0000011, 7'b0010011, 7'b1100111, 7'b0001111, 7'b1110011})
      imm = sra20;
    else if (op == 7'b0100011)
      imm = (sra20 & 32'hFFFF_FFE0) | ((w >> 7) & 32'h1F);
    else if (op == 7'b1100011) begin
      v = w[31] ? -4096 : 0;
      v = v + (int'(w[7]) << 11) + (int'(w[30:25]) << 5) + (int'(w[11:8]) << 1);
      imm = v;
    end else if (op inside {7'b0110111, 7'b0010111})
      imm = w & 32'hFFFF_F000;
    else if (op == 7'b1101111) begin
      v = w[31] ? -(1 << 20) : 0;
      v = v + (int'(w[19:12]) << 12) + (int'(w[20]) << 11) + (int'(w[30:21]) << 1);
      imm = v;
    end
`ifdef DECODE_ILLEGAL_CHECK_EN
    ill = !(op inside {7'b0000011, 7'b0010011, 7'b1100111, 7'b0001111, 7'b1110011,
                       7'b0100011, 7'b1100011, 7'b0110111, 7'b0010111, 7'b1101111,
                       7'b0110011});
`else
    ill = 1'b0;
`endif
    return {op, w[11:7], w[14:12], w[19:15], w[24:20], w[30], imm, use_imm, ill, pc};
  endfunction

  // Compare every output against the model's head (or zeros when empty)
  task automatic check_outputs();
    logic [91:0] exp;
    logic [91:0] obs;
    exp = '0;
    if (model_q.size() > 0) exp = ref_out(model_q[0].instr, model_q[0].pc);
    obs = {out_opcode, out_rd, out_funct3, out_rs1, out_rs2, out_funct7b5,
           out_imm, out_use_imm, out_illegal, out_pc};
    check("out_valid", 64'(out_valid), 64'(model_q.size() > 0));
    check("in_ready",  64'(in_ready),  64'(model_q.size() < DEPTH));
    check("regfields", 64'(obs[91:67]), 64'(exp[91:67]));
    check("funct7b5",  64'(obs[66]),    64'(exp[66]));
    check("out_imm",   64'(obs[65:34]), 64'(exp[65:34]));
    check("use_imm",   64'(obs[33]),    64'(exp[33]));
    check("illegal",   64'(obs[32]),    64'(exp[32]));
    check("out_pc",    64'(obs[31:0]),  64'(exp[31:0]));
  endtask

  // One clock: check, advance the model with the same handshake rules
  task automatic cycle();
    logic push;
    logic pop;
    ent_t e;
    check_outputs();
    push = in_valid && (model_q.size() < DEPTH) && !flush;
    pop  = (model_q.size() > 0) && out_ready && !flush;
    e.instr = in_instr;
    e.pc    = in_pc;
    @(posedge clk);
    if (flush) model_q.delete();
    else begin
      if (pop)  void'(model_q.pop_front());
      if (push) model_q.push_back(e);
    end
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic [31:0] w, input logic [31:0] pc,
                       input logic rdy, input logic fl);
    in_valid  = v;
    in_instr  = w;
    in_pc     = pc;
    out_ready = rdy;
    flush     = fl;
  endtask

  logic [6:0] ops [11] = '{7'b0000011, 7'b0010011, 7'b1100111, 7'b0001111, 7'b1110011,
                           7'b0100011, 7'b1100011, 7'b0110111, 7'b0010111, 7'b1101111,
                           7'b0110011};

  initial begin
    logic [31:0] r;
    int          idx;
    logic        exp_ill;

    // Reset state, during reset and just after release
    rst_n = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    #1;
    check_outputs();
    @(negedge clk);
    rst_n = 1'b1;
    cycle();

    // addi x1,x0,5 into an empty buffer
    drive(1'b1, 32'h0050_0093, 32'h0000_0100, 1'b0, 1'b0);
    cycle();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    check("addi_valid", 64'(out_valid), 64'd1);
    check("addi_rd",    64'(out_rd),    64'd1);
    check("addi_rs1",   64'(out_rs1),   64'd0);
    check("addi_imm",   64'(out_imm),   64'h5);
    check("addi_useimm", 64'(out_use_imm), 64'd1);
    check("addi_illegal", 64'(out_illegal), 64'd0);
    out_ready = 1'b1;
    cycle();

    // sw then lui, popped in order
    drive(1'b1, 32'h0020_A423, 32'h0000_0200, 1'b0, 1'b0);
    cycle();
    drive(1'b1, 32'h1234_52B7, 32'h0000_0204, 1'b0, 1'b0);
    cycle();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    cycle();
    check("sw_imm", 64'(out_imm), 64'h8);
    check("sw_rs1", 64'(out_rs1), 64'd1);
    check("sw_rs2", 64'(out_rs2), 64'd2);
    out_ready = 1'b1;
    cycle();
    check("lui_imm", 64'(out_imm), 64'h1234_5000);
    check("lui_rd",  64'(out_rd),  64'd5);
    cycle();

    // Back-pressure: three pushes with out_ready low, then one pop pulse
    drive(1'b1, 32'h0000_0013, 32'h0000_0300, 1'b0, 1'b0);
    cycle();
    drive(1'b1, 32'h0010_0113, 32'h0000_0304, 1'b0, 1'b0);
    cycle();
    drive(1'b1, 32'h0020_0193, 32'h0000_0308, 1'b0, 1'b0);
    check("full_ready", 64'(in_ready), 64'd0);
    cycle();
    check("held_ready", 64'(in_ready), 64'd0);
    out_ready = 1'b1;
    cycle();
    out_ready = 1'b0;
    check("pulse_ready", 64'(in_ready), 64'd1);
    cycle();
    in_valid = 1'b0;
    check("third_in_buf", 64'(in_ready), 64'd0);
    out_ready = 1'b1;
    cycle();
    check("second_head_pc", 64'(out_pc), 64'h0000_0308);
    cycle();
    out_ready = 1'b0;
    cycle();

    // Flush with two entries buffered and a push in the same cycle
    drive(1'b1, 32'h0030_0213, 32'h0000_0400, 1'b0, 1'b0);
    cycle();
    drive(1'b1, 32'h0040_0293, 32'h0000_0404, 1'b0, 1'b0);
    cycle();
    drive(1'b1, 32'hDEAD_B337, 32'h0000_0408, 1'b0, 1'b1);
    cycle();
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    check("flush_valid", 64'(out_valid), 64'd0);
    check("flush_ready", 64'(in_ready),  64'd1);
    cycle();
    cycle();

    // All-ones word
    drive(1'b1, 32'hFFFF_FFFF, 32'h0000_0500, 1'b0, 1'b0);
    cycle();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
`ifdef DECODE_ILLEGAL_CHECK_EN
    exp_ill = 1'b1;
`else
    exp_ill = 1'b0;
`endif
    check("ones_illegal", 64'(out_illegal), 64'(exp_ill));
    check("ones_imm",     64'(out_imm),     64'h0);
    out_ready = 1'b1;
    cycle();

    // Asynchronous reset between edges with one entry buffered
    drive(1'b1, 32'h0050_0093, 32'h0000_0600, 1'b0, 1'b0);
    cycle();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_valid", 64'(out_valid), 64'd0);
    check("async_imm",   64'(out_imm),   64'd0);
    model_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    cycle();
    cycle();

    // Randomized traffic
    for (int i = 0; i < 2000; i++) begin
      r   = $urandom();
      idx = $urandom_range(0, 12);
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 6);
      flush     = ($urandom_range(0, 15) == 0);
      in_instr  = (idx < 11) ? {r[31:7], ops[idx]} : $urandom();
      in_pc     = $urandom() & 32'hFFFF_FFFC;
      cycle();
    end
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    cycle();
    cycle();
    cycle();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
